activation_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit activation unit (the LUT-plus-interpolator sigmoid/tanh function block) among N requesters, typically the four LSTM gate datapaths of a layer. It accepts one operand per cycle over per-requester valid/ready, drives the shared unit from a register stage, and captures each result into a per-requester response slot held until it is accepted. At most one operation per requester is outstanding.

---
 rtl/act_arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 55 +++++
 rtl/activation_unit_arbiter.sv | 120 ++++++++++++
 tb/tb_activation_unit_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/act_arb_pkg.sv
// Shared parameters and types for the activation-unit arbiter slice.
package act_arb_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned N_REQ_DEF  = 4;

  // Requester tag width, never narrower than one bit.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned TAG_W = tag_width(N_REQ_DEF);

  typedef logic signed [DATA_W_DEF-1:0] slot_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational grant picker: round-robin from rr_ptr, or lowest-index-first
// when ACT_ARB_FIXED_PRIO_EN is defined (rr_ptr is then ignored).
module rr_picker
  import act_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned PTR_W = TAG_W
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

`ifdef ACT_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!grant_any && eligible[PTR_W'(k)]) begin
        grant[PTR_W'(k)] = 1'b1;
        grant_idx        = PTR_W'(k);
        grant_any        = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_t;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    idx_t     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // Wrap explicitly so non-power-of-two N_REQ scans correctly.
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_t = PTR_W'(idx);
      if (!grant_any && eligible[idx_t]) begin
        grant[idx_t] = 1'b1;
        grant_idx    = idx_t;
        grant_any    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/activation_unit_arbiter.sv
// Shares one external activation unit among N_REQ requesters with a 2-cycle
// register pipeline and per-requester response slots. ACT_ARB_FIXED_PRIO_EN selects fixed priority.
module activation_unit_arbiter
  import act_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       act_z,
  input  logic [DATA_W-1:0]       act_a,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [N_REQ*DATA_W-1:0] resp_data,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic                    busy
);

  localparam int unsigned TW = tag_width(N_REQ);

  logic                     stage_v;
  logic [TW-1:0]            stage_tag;
  logic [TW-1:0]            rr_ptr;
  logic [N_REQ-1:0]         eligible;
  logic [N_REQ-1:0]         grant;
  logic [TW-1:0]            grant_idx;
  logic                     grant_any;
  logic [DATA_W-1:0]        sel_data;
  logic signed [DATA_W-1:0] slot_q [N_REQ];

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i]
                  & ~(stage_v & (stage_tag == TW'(i)))
                  & (~resp_valid[i] | resp_ready[i]);
    end
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (TW)
  ) u_picker (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = rst ? '0 : grant;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef ACT_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == TW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v   <= 1'b0;
      stage_tag <= '0;
      act_z     <= '0;
    end else begin
      stage_v <= grant_any;
      if (grant_any) begin
        stage_tag <= grant_idx;
        act_z     <= sel_data;
      end
    end
  end

  // A capture landing on a slot being drained the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) slot_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (stage_v && (stage_tag == TW'(i))) begin
          slot_q[i]     <= act_a;
          resp_valid[i] <= 1'b1;
        end else if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    resp_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      resp_data[i*DATA_W +: DATA_W] = slot_q[i];
    end
  end

  assign busy = stage_v | (|resp_valid);

  capture_into_full_slot: assert property (
    @(posedge clk) disable iff (rst)
      !(stage_v && resp_valid[stage_tag] && !resp_ready[stage_tag])
  );

endmodule

// File: tb/tb_activation_unit_arbiter.sv
// Randomized and directed bench for activation_unit_arbiter against a
// transaction-level model; honours ACT_ARB_FIXED_PRIO_EN.
module tb_activation_unit_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0] req_data, resp_data;
  logic [W-1:0]   act_z, act_a;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: pending operation, response slots, next scan start.
  int           m_ptr;
  bit           m_sv;
  int           m_tag;
  logic [W-1:0] m_z;
  bit   [N-1:0] m_rv;
  logic [W-1:0] m_rd [N];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] act_fn(input logic [W-1:0] z);
    return {z[W-1], z[W-1:1]} ^ 8'h3C;
  endfunction

  assign act_a = act_fn(act_z);

  activation_unit_arbiter #(
    .N_REQ  (N),
    .DATA_W (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .act_z      (act_z),
    .act_a      (act_a),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_sv  = 0;
    m_tag = 0;
    m_z   = '0;
    m_rv  = '0;
    for (int i = 0; i < N; i++) m_rd[i] = '0;
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input logic [N-1:0] rr);
    int start;
`ifdef ACT_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (v[i] && !(m_sv && m_tag == i) && (!m_rv[i] || rr[i])) return i;
    end
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic [N-1:0] v,
                       input logic [N*W-1:0] d, input logic [N-1:0] rr);
    int             g;
    logic [N-1:0]   exp_ready;
    logic [N*W-1:0] exp_rd;
    @(negedge clk);
    rst        = r;
    req_valid  = v;
    req_data   = d;
    resp_ready = rr;
    #1;
    g = r ? -1 : model_grant(v, rr);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    for (int i = 0; i < N; i++) exp_rd[i*W +: W] = m_rd[i];
    check_val("req_ready",  64'(req_ready),  64'(exp_ready));
    check_val("act_z",      64'(act_z),      64'(m_z));
    check_val("resp_valid", 64'(resp_valid), 64'(m_rv));
    check_val("resp_data",  64'(resp_data),  64'(exp_rd));
    check_val("busy",       64'(busy),       64'(m_sv || (m_rv != 0)));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) if (m_rv[i] && rr[i]) m_rv[i] = 1'b0;
      if (m_sv) begin
        m_rv[m_tag] = 1'b1;
        m_rd[m_tag] = act_fn(m_z);
      end
      m_sv = (g >= 0);
      if (g >= 0) begin
        m_tag = g;
        m_z   = d[g*W +: W];
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  initial begin
    logic [N*W-1:0] d;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state, with requests presented while rst is held.
    cycle(1'b1, '0, '0, '0);
    cycle(1'b1, 4'hF, rand_data(), 4'hF);

    // Single request on requester 2 with operand 0x35.
    d = '0;
    d[2*W +: W] = 8'h35;
    cycle(1'b0, 4'b0100, d, '0);
    repeat (3) cycle(1'b0, '0, '0, '0);
    cycle(1'b0, '0, '0, 4'hF);

    // All requesters continuously valid and drained.
    repeat (12) cycle(1'b0, 4'hF, rand_data(), 4'hF);

    // Backpressure on slot 1, then release.
    repeat (8) cycle(1'b0, 4'hF, rand_data(), 4'b1101);
    repeat (4) cycle(1'b0, 4'hF, rand_data(), 4'hF);

    // Requester 0 re-granted in the cycle its slot drains.
    repeat (6) cycle(1'b0, 4'b0001, rand_data(), 4'b0001);

    // Reset with work in flight and slots full.
    repeat (3) cycle(1'b0, 4'hF, rand_data(), '0);
    cycle(1'b1, 4'hF, rand_data(), '0);
    repeat (4) cycle(1'b0, 4'hF, rand_data(), 4'hF);

    // Fixed-priority style load: requesters 0 and 3 always valid and drained.
    repeat (8) cycle(1'b0, 4'b1001, rand_data(), 4'hF);

    // Random traffic with occasional reset.
    repeat (400) begin
      cycle(($urandom_range(0, 63) == 0), N'($urandom), rand_data(),
            N'($urandom) | N'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
